// File: rtl/anim_seq_ctrl.sv
// Animation sequencer for a bank of eight frame decoders: steps a shared
// 5-bit frame index (one-shot, loop or ping-pong) and scans the decoders'
// seven-segment patterns onto a multiplexed display.
module anim_seq_ctrl #(
  parameter int unsigned FRAME_DIV = 2500000,
  parameter int unsigned SCAN_DIV  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause_tgl,
  input  logic [1:0]  mode,
  input  logic        dir,
  input  logic [1:0]  speed,
  input  logic [55:0] seg_bus,
  output logic [4:0]  frame,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg_n,
  output logic [7:0]  dig_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  // Frame prescaler must hold (2^24-1) * 2^3 - 1.
  localparam int PW = 27;
  localparam int SW = 16;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  state_e          state_q,      state_d;
  logic [4:0]      frame_q,      frame_d;
  logic [PW-1:0]   presc_q,      presc_d;
  logic            pp_down_q,    pp_down_d;
  logic            busy_q,       busy_d;
  logic            done_q,       done_d;
  logic [SW-1:0]   scan_presc_q, scan_presc_d;
  logic [2:0]      digit_q,      digit_d;
  logic [7:0]      dig_n_q,      dig_n_d;
  logic [6:0]      seg_n_q,      seg_n_d;

  logic [PW-1:0]   frame_limit;
  logic            step_tick;
  logic            is_pingpong;
  logic            is_oneshot;
  logic [5:0]      seg_base;

  assign is_pingpong = (mode == MODE_PINGPONG);
  assign is_oneshot  = (mode == MODE_ONESHOT);
  assign frame_limit = (PW'(FRAME_DIV) << speed) - PW'(1);
  assign step_tick   = (state_q == S_RUN) && (presc_q == frame_limit);

  // Next-state for the sequencer FSM, frame index and frame prescaler.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    frame_d   = frame_q;
    presc_d   = presc_q;
    pp_down_d = pp_down_q;
    done_d    = 1'b0;

    if (stop) begin
      state_d   = S_IDLE;
      frame_d   = 5'd0;
      presc_d   = '0;
      pp_down_d = 1'b0;
    end else if (start) begin
      state_d   = S_RUN;
      frame_d   = (dir && !is_pingpong) ? 5'd31 : 5'd0;
      presc_d   = '0;
      pp_down_d = 1'b0;
    end else if (pause_tgl && (state_q == S_RUN)) begin
      state_d = S_PAUSE;
    end else if (pause_tgl && (state_q == S_PAUSE)) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (!step_tick) begin
        presc_d = presc_q + PW'(1);
      end else begin
        presc_d = '0;
        if (is_pingpong) begin
          // Endpoints are shown once: bounce straight to the neighbour.
          if (!pp_down_q) begin
            if (frame_q == 5'd31) begin
              pp_down_d = 1'b1;
              frame_d   = 5'd30;
            end else begin
              frame_d = frame_q + 5'd1;
            end
          end else begin
            if (frame_q == 5'd0) begin
              pp_down_d = 1'b0;
              frame_d   = 5'd1;
            end else begin
              frame_d = frame_q - 5'd1;
            end
          end
        end else if (is_oneshot && (frame_q == (dir ? 5'd0 : 5'd31))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          // Loop (and the one-shot body) wraps naturally in 5 bits.
          frame_d = dir ? (frame_q - 5'd1) : (frame_q + 5'd1);
        end
      end
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  // Next-state for the free-running display scan.
  always_comb begin
    scan_presc_d = scan_presc_q + SW'(1);
    digit_d      = digit_q;
    if (scan_presc_q == SW'(SCAN_DIV - 1)) begin
      scan_presc_d = '0;
      digit_d      = digit_q + 3'd1;
    end
    // Both drives derive from the same next digit so they update together.
    seg_base = 6'(digit_d) * 6'd7;
    dig_n_d  = ~(8'd1 << digit_d);
    seg_n_d  = seg_bus[seg_base +: 7];
  end

  // Single register stage for FSM state and every registered output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      frame_q      <= 5'd0;
      presc_q      <= '0;
      pp_down_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      scan_presc_q <= '0;
      digit_q      <= 3'd0;
      dig_n_q      <= 8'b1111_1110;
      seg_n_q      <= 7'b111_1111;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      presc_q      <= presc_d;
      pp_down_q    <= pp_down_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      scan_presc_q <= scan_presc_d;
      digit_q      <= digit_d;
      dig_n_q      <= dig_n_d;
      seg_n_q      <= seg_n_d;
    end
  end

  assign frame = frame_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign seg_n = seg_n_q;
  assign dig_n = dig_n_q;

endmodule

// File: tb/tb_anim_seq_ctrl.sv
// Scoreboard bench for anim_seq_ctrl with FRAME_DIV=4, SCAN_DIV=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_anim_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause_tgl;
  logic [1:0]  mode;
  logic        dir;
  logic [1:0]  speed;
  logic [55:0] seg_bus;
  logic [4:0]  frame;
  logic        busy;
  logic        done;
  logic [6:0]  seg_n;
  logic [7:0]  dig_n;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [4:0] frame;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic r;
    logic st;
    logic sp;
    logic pt;
    logic dr;
    exp_t e;
  } stim_t;

  stim_t stim[$];
  exp_t  sb[$];
  logic [14:0] scan_sb[$];

  anim_seq_ctrl #(.FRAME_DIV(4), .SCAN_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause_tgl (pause_tgl),
    .mode      (mode),
    .dir       (dir),
    .speed     (speed),
    .seg_bus   (seg_bus),
    .frame     (frame),
    .busy      (busy),
    .done      (done),
    .seg_n     (seg_n),
    .dig_n     (dig_n)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, st, sp, pt, dr, input logic [4:0] f,
                     input logic b, d);
    stim_t s;
    s.r = r; s.st = st; s.sp = sp; s.pt = pt; s.dr = dr;
    s.e = '{frame: f, busy: b, done: d};
    stim.push_back(s);
  endtask

  // Apply one cycle of stimulus and return at the following falling edge.
  task automatic drive(input stim_t s);
    rst = s.r; start = s.st; stop = s.sp; pause_tgl = s.pt; dir = s.dr;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause_tgl = 1'b0;
  endtask

  task automatic test_reset();
    stim_t cur;
    exp_t  e;
    add(1, 0, 0, 0, 0, 5'd0, 0, 0);
    add(1, 1, 0, 1, 0, 5'd0, 0, 0);
    while (stim.size() > 0) begin
      cur = stim.pop_front();
      sb.push_back(cur.e);
      drive(cur);
      e = sb.pop_front();
      tests_run++;
      if ({frame, busy, done} !== e) begin
        tests_failed++;
        $display("FAIL reset_state: got frame=%0d busy=%b done=%b, want frame=%0d busy=%b done=%b",
                 frame, busy, done, e.frame, e.busy, e.done);
      end
      tests_run++;
      if ({dig_n, seg_n} !== {8'b1111_1110, 7'b111_1111}) begin
        tests_failed++;
        $display("FAIL reset_scan: got dig_n=%b seg_n=%b, want 11111110 1111111", dig_n, seg_n);
      end
    end
  endtask

  task automatic test_scan();
    stim_t cur;
    logic [14:0] e;
    int d;
    add(1, 0, 0, 0, 0, 5'd0, 0, 0);
    cur = stim.pop_front();
    scan_sb.push_back({8'b1111_1110, 7'b111_1111});
    drive(cur);
    for (int j = 1; j <= 33; j++) begin
      e = scan_sb.pop_front();
      tests_run++;
      if ({dig_n, seg_n} !== e) begin
        tests_failed++;
        $display("FAIL scan step %0d: got dig_n=%b seg_n=%b, want dig_n=%b seg_n=%b",
                 j - 1, dig_n, seg_n, e[14:7], e[6:0]);
      end
      if (j <= 32) begin
        d = (j / 2) % 8;
        scan_sb.push_back({~(8'd1 << d), 7'(d)});
        add(0, 0, 0, 0, 0, 5'd0, 0, 0);
        drive(stim.pop_front());
      end
    end
  endtask

  task automatic test_oneshot();
    stim_t cur;
    exp_t  e;
    int    n = 0;
    mode = 2'b00; speed = 2'd0;
    for (int i = 0; i < 128; i++) add(0, i == 0, 0, 0, 0, 5'(i / 4), 1, 0);
    add(0, 0, 0, 0, 0, 5'd31, 0, 1);
    add(0, 0, 0, 1, 0, 5'd31, 0, 0);
    add(0, 0, 0, 0, 0, 5'd31, 0, 0);
    add(0, 0, 0, 0, 0, 5'd31, 0, 0);
    while (stim.size() > 0) begin
      cur = stim.pop_front();
      sb.push_back(cur.e);
      drive(cur);
      e = sb.pop_front();
      tests_run++;
      if ({frame, busy, done} !== e) begin
        tests_failed++;
        $display("FAIL oneshot cyc %0d: got frame=%0d busy=%b done=%b, want frame=%0d busy=%b done=%b",
                 n, frame, busy, done, e.frame, e.busy, e.done);
      end
      n++;
    end
  endtask

  task automatic test_pingpong();
    stim_t cur;
    exp_t  e;
    int    seq[$];
    int    n = 0;
    mode = 2'b10; speed = 2'd1;
    for (int f = 0; f <= 31; f++) seq.push_back(f);
    for (int f = 30; f >= 0; f--) seq.push_back(f);
    for (int f = 1; f <= 3; f++) seq.push_back(f);
    foreach (seq[i])
      for (int r = 0; r < 8; r++)
        add(0, (i == 0) && (r == 0), 0, 0, 1, 5'(seq[i]), 1, 0);
    while (stim.size() > 0) begin
      cur = stim.pop_front();
      sb.push_back(cur.e);
      drive(cur);
      e = sb.pop_front();
      tests_run++;
      if ({frame, busy, done} !== e) begin
        tests_failed++;
        $display("FAIL pingpong cyc %0d: got frame=%0d busy=%b done=%b, want frame=%0d busy=%b done=%b",
                 n, frame, busy, done, e.frame, e.busy, e.done);
      end
      n++;
    end
  endtask

  task automatic test_loop_pause();
    stim_t cur;
    exp_t  e;
    int    n = 0;
    mode = 2'b01; speed = 2'd0;
    for (int f = 31; f >= 21; f--)
      for (int r = 0; r < 4; r++) add(0, (f == 31) && (r == 0), 0, 0, 1, 5'(f), 1, 0);
    add(0, 0, 0, 0, 1, 5'd20, 1, 0);
    add(0, 0, 0, 0, 1, 5'd20, 1, 0);
    add(0, 0, 0, 1, 1, 5'd20, 1, 0);               // enter pause, prescaler at 1
    for (int i = 0; i < 49; i++) add(0, 0, 0, 0, 1, 5'd20, 1, 0);
    add(0, 0, 0, 1, 1, 5'd20, 1, 0);               // resume
    add(0, 0, 0, 0, 1, 5'd20, 1, 0);
    add(0, 0, 0, 0, 1, 5'd20, 1, 0);
    for (int f = 19; f >= -2; f--)
      for (int r = 0; r < 4; r++) add(0, 0, 0, 0, 1, 5'(f), 1, 0);
    while (stim.size() > 0) begin
      cur = stim.pop_front();
      sb.push_back(cur.e);
      drive(cur);
      e = sb.pop_front();
      tests_run++;
      if ({frame, busy, done} !== e) begin
        tests_failed++;
        $display("FAIL loop_pause cyc %0d: got frame=%0d busy=%b done=%b, want frame=%0d busy=%b done=%b",
                 n, frame, busy, done, e.frame, e.busy, e.done);
      end
      n++;
    end
  endtask

  task automatic test_start_stop();
    stim_t cur;
    exp_t  e;
    int    n = 0;
    mode = 2'b11; speed = 2'd0;
    for (int i = 0; i < 6; i++) add(0, i == 0, 0, 0, 0, 5'(i / 4), 1, 0);
    add(0, 1, 1, 0, 0, 5'd0, 0, 0);                // stop beats start
    add(0, 0, 0, 1, 0, 5'd0, 0, 0);                // pause ignored in IDLE
    add(0, 0, 0, 0, 0, 5'd0, 0, 0);
    add(0, 0, 0, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 9; i++) add(0, i == 0, 0, 0, 0, 5'(i / 4), 1, 0);
    add(0, 1, 0, 0, 1, 5'd31, 1, 0);               // restart mid-frame, count down
    for (int i = 1; i < 6; i++) add(0, 0, 0, 0, 1, (i < 4) ? 5'd31 : 5'd30, 1, 0);
    while (stim.size() > 0) begin
      cur = stim.pop_front();
      sb.push_back(cur.e);
      drive(cur);
      e = sb.pop_front();
      tests_run++;
      if ({frame, busy, done} !== e) begin
        tests_failed++;
        $display("FAIL start_stop cyc %0d: got frame=%0d busy=%b done=%b, want frame=%0d busy=%b done=%b",
                 n, frame, busy, done, e.frame, e.busy, e.done);
      end
      n++;
    end
  endtask

  task automatic test_reset_pause();
    stim_t cur;
    exp_t  e;
    int    n = 0;
    mode = 2'b01; speed = 2'd0;
    for (int i = 0; i <= 36; i++) add(0, i == 0, 0, 0, 0, 5'(i / 4), 1, 0);
    add(0, 0, 0, 1, 0, 5'd9, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 5'd9, 1, 0);
    add(1, 0, 0, 0, 0, 5'd0, 0, 0);
    add(0, 0, 0, 1, 0, 5'd0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 5'd0, 0, 0);
    while (stim.size() > 0) begin
      cur = stim.pop_front();
      sb.push_back(cur.e);
      drive(cur);
      e = sb.pop_front();
      tests_run++;
      if ({frame, busy, done} !== e) begin
        tests_failed++;
        $display("FAIL reset_pause cyc %0d: got frame=%0d busy=%b done=%b, want frame=%0d busy=%b done=%b",
                 n, frame, busy, done, e.frame, e.busy, e.done);
      end
      if (cur.r) begin
        tests_run++;
        if ({dig_n, seg_n} !== {8'b1111_1110, 7'b111_1111}) begin
          tests_failed++;
          $display("FAIL reset_pause_scan: got dig_n=%b seg_n=%b, want 11111110 1111111",
                   dig_n, seg_n);
        end
      end
      n++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause_tgl = 1'b0;
    mode = 2'b00; dir = 1'b0; speed = 2'd0;
    for (int k = 0; k < 8; k++) seg_bus[7*k +: 7] = 7'(k);
    @(negedge clk);
    test_reset();
    test_scan();
    test_oneshot();
    test_pingpong();
    test_loop_pause();
    test_start_stop();
    test_reset_pause();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/anim_seq_ctrl.md
ANIM_SEQ_CTRL -- requirements
Module: anim_seq_ctrl

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 2500000, base clock cycles per frame step at speed 0 (legal range 2..2^24-1).
REQ-002 SHALL have parameter SCAN_DIV, default 5000, clock cycles per display digit slot (legal range 2..2^16-1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; sampled each cycle; begins/restarts animation.
REQ-006 SHALL have port stop  input  1  level; sampled each cycle; aborts to IDLE.
REQ-007 SHALL have port pause_tgl  input  1  single-cycle pulse; toggles RUN/PAUSE.
REQ-008 SHALL have port mode  input  2  00 one-shot, 01 loop, 10 ping-pong, 11 treated as loop.
REQ-009 SHALL have port dir  input  1  0 = count up, 1 = count down; ignored in ping-pong.
REQ-010 SHALL have port speed  input  2  frame period = FRAME_DIV * 2^speed cycles.
REQ-011 SHALL have port seg_bus  input  56  seven-segment patterns from the 8 frame decoders, digit k at bits [7k+6:7k], active-low.
REQ-012 SHALL have port frame  output  5  registered frame index driven to all frame decoders.
REQ-013 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on one-shot completion.
REQ-015 SHALL have port seg_n  output  7  registered segment drive, active-low.
REQ-016 SHALL have port dig_n  output  8  registered digit enable, active-low one-hot.

Function
REQ-017 SHALL implement states IDLE, RUN, PAUSE, DONE in a registered FSM.
REQ-018 Priority each cycle SHALL be: rst > stop > start > pause_tgl > frame step.
REQ-019 stop in any state SHALL go to IDLE next cycle with frame=0, prescaler=0.
REQ-020 start in any state (stop low) SHALL go to RUN next cycle, frame = start frame (0 if dir=0 or mode=10, 31 if dir=1 and mode!=10), prescaler=0, ping-pong direction=up.
REQ-021 pause_tgl SHALL move RUN->PAUSE and PAUSE->RUN; ignored in IDLE and DONE; prescaler and frame hold in PAUSE.
REQ-022 Prescaler SHALL count cycles in RUN only; step tick when count = FRAME_DIV*2^speed - 1, then count clears; speed and mode changes take effect from the next cycle's compare.
REQ-023 On step tick, loop: frame +1 (dir=0) or -1 (dir=1) modulo 32 (31->0, 0->31).
REQ-024 On step tick, one-shot: advance as loop unless frame is at end value (31 up, 0 down); at end value go to DONE, frame holds, done=1 for exactly that transition cycle.
REQ-025 On step tick, ping-pong: move in internal direction; at 31 going up, reverse and output 30; at 0 going down, reverse and output 1; endpoints never repeated.
REQ-026 Frame step latency: frame SHALL change on the clock edge where the tick is detected (output valid the following cycle).
REQ-027 DONE SHALL hold frame until start or stop; busy=0 in IDLE and DONE.
REQ-028 Scan counter (digit 0..7) and scan prescaler SHALL run continuously in all states, advancing digit every SCAN_DIV cycles, wrapping 7->0.
REQ-029 dig_n SHALL be ~(1<<digit) and seg_n SHALL be seg_bus slice of that digit, both registered on the same edge (no one-cycle skew between them).

Reset
REQ-030 rst high SHALL set state=IDLE, frame=0, busy=0, done=0, both prescalers=0, digit=0, dig_n=8'b11111110, seg_n=7'b1111111 on next edge, overriding all inputs.
REQ-031 rst mid-RUN or mid-PAUSE SHALL discard ping-pong direction and pause status; no done pulse.

Verification (FRAME_DIV=4, SCAN_DIV=2)
REQ-032 mode=00, dir=0, speed=0, start 1 cycle -> frame 0..31 each held 4 cycles, DONE after 128 cycles in RUN, done high 1 cycle, frame stays 31, busy=0.
REQ-033 mode=10, speed=1 -> frame 0,1..31,30..0,1 with 8 cycles per frame; 31 and 0 each shown once per turn.
REQ-034 mode=01, dir=1 -> frame 31,30..0,31 wrap; pause_tgl at frame 20 -> frame 20 held 50 cycles, busy=1; second pause_tgl -> resumes with remaining prescaler count.
REQ-035 start and stop asserted same cycle during RUN -> IDLE, frame=0; start alone during RUN -> frame reloads to start value, prescaler restarts.
REQ-036 seg_bus digit k = 7'(k) pattern -> dig_n walks 11111110..01111111 every 2 cycles, seg_n always matches enabled digit's slice on same cycle.
REQ-037 rst asserted in PAUSE at frame 9 -> next cycle IDLE, frame=0, dig_n=11111110, seg_n=1111111, done never pulses.
